// File: rtl/level_engine_if.sv
// rtl/level_engine_if.sv - handshake bundle between the game control unit and one level engine
//
// Purpose: groups the level enable, the player guess strobe and every engine
// status output so a level engine connects to its controller through one port.
//
// Signals:
//   level_start  controller -> engine  level enable, held high for the whole level
//   guess_valid  controller -> engine  player guess strobe
//   guess_value  controller -> engine  player guess, taken when guess_valid & guess_ready
//   level_done   engine -> controller  level complete, held until level_start drops
//   guesses      engine -> controller  wrong-guess count, saturating at 7
//   target       engine -> controller  current target value
//   show_target  engine -> controller  target is to be displayed
//   guess_ready  engine -> controller  engine accepting a guess
//   hit / miss   engine -> controller  one-cycle judgement pulses
//   round        engine -> controller  correct guesses so far
interface level_engine_if #(
  parameter int VAL_W = 4
);
  logic             level_start;
  logic             guess_valid;
  logic [VAL_W-1:0] guess_value;
  logic             level_done;
  logic [2:0]       guesses;
  logic [VAL_W-1:0] target;
  logic             show_target;
  logic             guess_ready;
  logic             hit;
  logic             miss;
  logic [3:0]       round;

  modport slave (
    input  level_start, guess_valid, guess_value,
    output level_done, guesses, target, show_target, guess_ready, hit, miss, round
  );

  modport master (
    output level_start, guess_valid, guess_value,
    input  level_done, guesses, target, show_target, guess_ready, hit, miss, round
  );
endinterface

// File: rtl/level_engine.sv
// rtl/level_engine.sv - guessing-level responder for the game control unit
//
// Purpose: while level_start is high, shows a pseudo-random target for
// SHOW_CYCLES cycles, then accepts guesses; a correct guess advances the round
// and shows a new target, a wrong one bumps the saturating miss counter and
// re-opens the guess window. level_done rises with the ROUNDS-th hit.
//
// Ports:
//   Clk    system clock, all logic on the rising edge
//   reset  synchronous active-low reset
//   bus    level_engine_if slave side (level_start/guess_* in, status out)
module level_engine #(
  parameter int          ROUNDS      = 4,
  parameter int          VAL_W       = 4,
  parameter int          SHOW_CYCLES = 16,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic         Clk,
  input  logic         reset,
  level_engine_if.slave bus
);

  localparam int TW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(SHOW_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHOW  = 3'd1,
    WAIT  = 3'd2,
    JUDGE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [VAL_W-1:0] target_q, target_d;
  logic [VAL_W-1:0] guess_q, guess_d;
  logic [2:0]       guesses_q, guesses_d;
  logic [3:0]       round_q, round_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      timer_q   <= '0;
      target_q  <= '0;
      guess_q   <= '0;
      guesses_q <= '0;
      round_q   <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      timer_q   <= timer_d;
      target_q  <= target_d;
      guess_q   <= guess_d;
      guesses_q <= guesses_d;
      round_q   <= round_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    target_d  = target_q;
    guess_d   = guess_q;
    guesses_d = guesses_q;
    round_d   = round_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    // Right-shifting Galois form of x^16+x^14+x^13+x^11; free-running so the
    // target depends on how long the player took, not only on the seed.
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    if (!bus.level_start && state_q != IDLE) begin
      // Abort wins over any guess or judgement this cycle; counters are kept
      // so the controller can still read the final miss count.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.level_start) begin
            state_d   = SHOW;
            guesses_d = '0;
            round_d   = '0;
            target_d  = lfsr_q[VAL_W-1:0];
            timer_d   = '0;
          end
        end
        SHOW: begin
          if (timer_q == T_LAST) begin
            state_d = WAIT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        WAIT: begin
          if (bus.guess_valid) begin
            guess_d = bus.guess_value;
            state_d = JUDGE;
          end
        end
        JUDGE: begin
          if (guess_q == target_q) begin
            hit_d   = 1'b1;
            round_d = round_q + 4'd1;
            if (round_q + 4'd1 == 4'(ROUNDS)) begin
              state_d = DONE;
            end else begin
              state_d  = SHOW;
              target_d = lfsr_q[VAL_W-1:0];
              timer_d  = '0;
            end
          end else begin
            miss_d    = 1'b1;
            guesses_d = (guesses_q == 3'd7) ? 3'd7 : guesses_q + 3'd1;
            state_d   = WAIT;
          end
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.show_target = (state_q == SHOW);
  assign bus.guess_ready = (state_q == WAIT);
  assign bus.level_done  = (state_q == DONE);
  assign bus.target      = target_q;
  assign bus.guesses     = guesses_q;
  assign bus.round       = round_q;
  assign bus.hit         = hit_q;
  assign bus.miss        = miss_q;

endmodule

// File: tb/tb_level_engine.sv
// tb/tb_level_engine.sv - self-checking bench for level_engine
module tb_level_engine;
  localparam int          ROUNDS      = 4;
  localparam int          VAL_W       = 4;
  localparam int          SHOW_CYCLES = 16;
  localparam logic [15:0] SEED        = 16'hACE1;

  localparam int P_IDLE = 0, P_SHOW = 1, P_WAIT = 2, P_JUDGE = 3, P_DONE = 4;

  logic Clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  logic chk_en = 1'b0;

  level_engine_if #(.VAL_W(VAL_W)) bus();

  level_engine #(
    .ROUNDS(ROUNDS), .VAL_W(VAL_W), .SHOW_CYCLES(SHOW_CYCLES), .SEED(SEED)
  ) dut (
    .Clk(Clk),
    .reset(rst_n),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int               m_phase = P_IDLE;
  int               m_show_left = 0;
  logic [15:0]      m_lfsr = SEED;
  logic [VAL_W-1:0] m_target = '0;
  logic [VAL_W-1:0] m_pend = '0;
  int               m_guesses = 0;
  int               m_round = 0;
  logic             m_hit = 1'b0;
  logic             m_miss = 1'b0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge Clk) begin
    logic [15:0] cur;
    cur    = m_lfsr;
    m_hit  = 1'b0;
    m_miss = 1'b0;
    if (!rst_n) begin
      m_lfsr = SEED; m_phase = P_IDLE; m_show_left = 0;
      m_target = '0; m_guesses = 0; m_round = 0;
    end else begin
      m_lfsr = lfsr_step(m_lfsr);
      if (m_phase != P_IDLE && !bus.level_start) begin
        m_phase = P_IDLE;
      end else begin
        case (m_phase)
          P_IDLE: if (bus.level_start) begin
            m_phase = P_SHOW; m_show_left = SHOW_CYCLES;
            m_guesses = 0; m_round = 0; m_target = cur[VAL_W-1:0];
          end
          P_SHOW: begin
            m_show_left--;
            if (m_show_left == 0) m_phase = P_WAIT;
          end
          P_WAIT: if (bus.guess_valid) begin
            m_pend = bus.guess_value; m_phase = P_JUDGE;
          end
          P_JUDGE: begin
            if (m_pend == m_target) begin
              m_hit = 1'b1;
              m_round++;
              if (m_round == ROUNDS) m_phase = P_DONE;
              else begin
                m_phase = P_SHOW; m_show_left = SHOW_CYCLES; m_target = cur[VAL_W-1:0];
              end
            end else begin
              m_miss = 1'b1;
              if (m_guesses < 7) m_guesses++;
              m_phase = P_WAIT;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("show_target", bus.show_target, m_phase == P_SHOW);
      chk("guess_ready", bus.guess_ready, m_phase == P_WAIT);
      chk("level_done",  bus.level_done,  m_phase == P_DONE);
      chk("target",      bus.target,      m_target);
      chk("guesses",     bus.guesses,     m_guesses);
      chk("round",       bus.round,       m_round);
      chk("hit",         bus.hit,         m_hit);
      chk("miss",        bus.miss,        m_miss);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.guess_ready && n < 200) begin
      tick(1);
      n++;
    end
    chk("wait_ready_timeout", bus.guess_ready, 1'b1);
  endtask

  // Submits one guess; returns in the judgement result cycle (N+2).
  task automatic do_guess(input logic [VAL_W-1:0] v);
    wait_ready();
    bus.guess_valid = 1'b1;
    bus.guess_value = v;
    tick(1);
    bus.guess_valid = 1'b0;
    tick(1);
  endtask

  task automatic measure_show(input string name);
    int cnt = 0;
    while (bus.show_target && cnt < 100) begin
      cnt++;
      tick(1);
    end
    chk(name, cnt, SHOW_CYCLES);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VAL_W-1:0] t;
    int hits;
    rst_n = 1'b0;
    bus.level_start = 1'b1;
    bus.guess_valid = 1'b0;
    bus.guess_value = '0;

    // Reset held 3 cycles with level_start high
    tick(1);
    chk_en = 1'b1;
    tick(2);
    chk("rst_show",   bus.show_target, 1'b0);
    chk("rst_ready",  bus.guess_ready, 1'b0);
    chk("rst_done",   bus.level_done,  1'b0);
    chk("rst_target", bus.target,      '0);
    chk("rst_round",  bus.round,       '0);
    rst_n = 1'b1;
    tick(1);
    chk("first_show",   bus.show_target, 1'b1);
    chk("first_target", bus.target,      4'h1);

    // Clean level
    for (int r = 1; r <= ROUNDS; r++) begin
      measure_show("show_window");
      do_guess(bus.target);
      chk("clean_hit",     bus.hit,     1'b1);
      chk("clean_round",   bus.round,   r);
      chk("clean_guesses", bus.guesses, 0);
      chk("clean_done",    bus.level_done, r == ROUNDS);
    end

    // DONE hold with ignored guesses
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      bus.guess_valid = i[0];
      bus.guess_value = bus.target;
      tick(1);
      hits += int'(bus.hit);
      chk("done_hold", bus.level_done, 1'b1);
    end
    bus.guess_valid = 1'b0;
    chk("done_hits", hits, 0);
    bus.level_start = 1'b0;
    tick(1);
    chk("done_drop", bus.level_done, 1'b0);

    // Wrong guesses then a correct one
    bus.level_start = 1'b1;
    tick(1);
    wait_ready();
    t = bus.target;
    for (int i = 1; i <= 3; i++) begin
      do_guess(t ^ 4'h1);
      chk("wrong_miss",    bus.miss,        1'b1);
      chk("wrong_guesses", bus.guesses,     i);
      chk("wrong_target",  bus.target,      t);
      chk("wrong_noshow",  bus.show_target, 1'b0);
    end
    do_guess(t);
    chk("retry_hit",   bus.hit,   1'b1);
    chk("retry_round", bus.round, 1);

    // Saturation over 9 misses in a fresh level
    bus.level_start = 1'b0;
    tick(1);
    bus.level_start = 1'b1;
    tick(1);
    wait_ready();
    t = bus.target;
    for (int i = 1; i <= 9; i++) begin
      do_guess(t ^ 4'h1);
      chk("sat_miss",    bus.miss,    1'b1);
      chk("sat_guesses", bus.guesses, (i > 7) ? 7 : i);
    end

    // Abort in WAIT coinciding with a guess
    bus.guess_valid = 1'b1;
    bus.guess_value = t;
    bus.level_start = 1'b0;
    tick(1);
    bus.guess_valid = 1'b0;
    chk("abort_ready",   bus.guess_ready, 1'b0);
    chk("abort_show",    bus.show_target, 1'b0);
    chk("abort_guesses", bus.guesses,     7);
    tick(1);
    chk("abort_hit",  bus.hit,  1'b0);
    chk("abort_miss", bus.miss, 1'b0);
    bus.level_start = 1'b1;
    tick(1);
    chk("restart_guesses", bus.guesses,     0);
    chk("restart_round",   bus.round,       0);
    chk("restart_show",    bus.show_target, 1'b1);

    // Abort while a correct guess is being judged
    wait_ready();
    bus.guess_valid = 1'b1;
    bus.guess_value = bus.target;
    tick(1);
    bus.guess_valid = 1'b0;
    bus.level_start = 1'b0;
    tick(1);
    chk("judge_abort_hit",   bus.hit,   1'b0);
    chk("judge_abort_round", bus.round, 0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/level_engine.md
Name: level_engine

Overview:
- Level-side responder for the game control unit's level handshake.
- Holding `level_start` high runs one guessing level:
  - shows a pseudo-random target;
  - accepts player guesses;
  - counts wrong guesses;
  - raises `level_done` after ROUNDS correct guesses.
- Drives the controller's `level*Done` and `guesses` inputs; one instance per level, difficulty set by parameters.

Parameters:
ROUNDS, 4, correct guesses required to finish the level (1..15)
VAL_W, 4, width of target/guess value (1..16)
SHOW_CYCLES, 16, cycles the target is displayed per round (>=1; 50_000_000 on board)
SEED, 16'hACE1, LFSR reset value (non-zero)

Ports:
Clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
level_start  in  1  level enable from control unit; held high for the whole level
guess_valid  in  1  player guess strobe
guess_value  in  VAL_W  player guess, sampled when guess_valid & guess_ready
level_done  out  1  level complete; held until level_start drops
guesses  out  3  wrong-guess count, saturating at 7
target  out  VAL_W  current target value
show_target  out  1  high while target is to be displayed
guess_ready  out  1  engine accepting a guess
hit  out  1  one-cycle pulse: correct guess judged
miss  out  1  one-cycle pulse: wrong guess judged
round  out  4  correct guesses so far

Behaviour:
- Reset (`reset`=0 at edge):
  - state IDLE;
  - all outputs 0;
  - LFSR=SEED;
  - timer=0.
  - Reset overrides every other input, including mid-level.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11.
  - Advances every cycle out of reset, regardless of state.
  - Target = lfsr[VAL_W-1:0], sampled on entry to SHOW.
- States: IDLE, SHOW, WAIT, JUDGE, DONE.
- IDLE:
  - Outputs `show_target`/`guess_ready`/`level_done` are 0; `guesses` and `round` hold their last values.
  - `level_start`=1 → SHOW next cycle. On that edge: `guesses`=0, `round`=0, `target` loaded, timer=0.
- SHOW:
  - `show_target`=1; timer increments each cycle.
  - After exactly SHOW_CYCLES cycles in SHOW → WAIT, and `show_target` drops.
- WAIT:
  - `guess_ready`=1 (combinational from state).
  - `guess_valid`=1 → JUDGE; `guess_value` latched. No other exits besides abort.
- JUDGE (exactly 1 cycle, `guess_ready`=0; guesses during JUDGE are ignored):
  - Latched guess == `target`:
    - `hit` pulses next cycle; `round`+1.
    - If the new `round` == ROUNDS → DONE.
    - Else → SHOW with a new target and timer=0.
  - Mismatch:
    - `miss` pulses next cycle; `guesses`+1, saturating at 7.
    - → WAIT with the same target (retry without redisplay).
- DONE:
  - `level_done`=1; `round` holds ROUNDS.
  - Exits only via abort.
- Abort: `level_start`=0 in any non-IDLE state → IDLE next cycle.
  - Takes priority over `guess_valid` and over the JUDGE result: no `hit`/`miss`, no counter change that cycle.
  - `level_done` returns to 0.
- Latency:
  - guess accepted at cycle N → `hit`/`miss`/counter update visible at N+2.
  - `level_done` asserted in the same cycle as the final `hit`.
- `guesses` is never cleared by abort; only by reset or a new level start. The controller can therefore read the value `guesses` held at level end.
- Engine never stops on `guesses` > 2; terminating the game is the control unit's job.

Test Plan:
- Reset: hold `reset`=0 for 3 cycles with `level_start`=1 → all outputs 0, state IDLE. Release → `show_target`=1 next cycle, `target`=SEED-derived value.
- Clean level (ROUNDS=4, SHOW_CYCLES=16):
  - Stimulus: in each WAIT, guess = `target`.
  - Required: 4 `hit` pulses; `round` 1,2,3,4; `guesses`=0.
  - Required: `level_done`=1 in the cycle of the 4th `hit`, and 16-cycle `show_target` windows between rounds.
- Wrong guesses:
  - Stimulus: `target`^1 submitted three times, then the correct value.
  - Required: `miss` ×3; `guesses` 1,2,3; `target` unchanged; no SHOW between retries; then `hit` with `round`=1.
- Saturation: 9 wrong guesses → `guesses` stops at 7; `miss` still pulses 9 times.
- Abort:
  - Stimulus: drop `level_start` in the same cycle as `guess_valid` in WAIT.
  - Required: IDLE next cycle; no `hit`/`miss`; `guesses` retained.
  - Stimulus: re-raise `level_start`. Required: `guesses`=0, `round`=0.
- DONE hold: hold `level_start`=1 for 20 cycles after completion → `level_done` stays 1 and `guess_valid` is ignored. Drop `level_start` → `level_done`=0 next cycle.
